// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_aluctrl;
  logic [2*WIDTH-1:0] req_srca;
  logic [2*WIDTH-1:0] req_srcb;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;

  modport master (
    output req_valid, req_aluctrl, req_srca, req_srcb, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_aluctrl, req_srca, req_srcb, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter/sequencer in front of one shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [2:0]          alu_ctrl,
  output logic [WIDTH-1:0]    alu_srca,
  output logic [WIDTH-1:0]    alu_srcb,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] srca_q, srca_d;
  logic [WIDTH-1:0] srcb_q, srcb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [2:0]       fld_ctrl [2];
  logic [WIDTH-1:0] fld_srca [2];
  logic [WIDTH-1:0] fld_srcb [2];
  logic [1:0]       req_ready_c;
  logic [1:0]       rsp_valid_c;
  logic             win;
  logic             prio;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign fld_ctrl[gi] = bus.req_aluctrl[3*gi +: 3];
      assign fld_srca[gi] = bus.req_srca[WIDTH*gi +: WIDTH];
      assign fld_srcb[gi] = bus.req_srcb[WIDTH*gi +: WIDTH];
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic ptr_q, ptr_d;

  // Loser of the last completed operation gets the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP && bus.rsp_ready[gnt_q]) begin
      ptr_d = ~gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign prio = ptr_q;
`endif

  always_comb begin
    unique case (bus.req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = prio;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ctrl_d      = ctrl_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    result_d    = result_q;
    zero_d      = zero_q;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c[win] = 1'b1;
          gnt_d            = win;
          ctrl_d           = fld_ctrl[win];
          srca_d           = fld_srca[win];
          srcb_d           = fld_srcb[win];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_c[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      ctrl_q   <= 3'b000;
      srca_q   <= '0;
      srcb_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ctrl_q   <= ctrl_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // state_q is already IDLE during reset, so ready must be masked explicitly.
  assign bus.req_ready  = rst_n ? req_ready_c : 2'b00;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign alu_ctrl       = ctrl_q;
  assign alu_srca       = srca_q;
  assign alu_srcb       = srcb_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on the alu_* port.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_srca, alu_srcb, alu_result;
  logic         alu_zero;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_share_arbiter_if #(.WIDTH(W)) bus ();

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_srca + alu_srcb;
      3'b001: alu_result = alu_srca - alu_srcb;
      3'b010: alu_result = alu_srca & alu_srcb;
      3'b011: alu_result = alu_srca | alu_srcb;
      3'b100: alu_result = alu_srca ^ alu_srcb;
      3'b101: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      3'b110: alu_result = alu_srca << alu_srcb[4:0];
      default: alu_result = alu_srca >> alu_srcb[4:0];
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic        gnt;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Drives the vector on its requester, junk on the other one.
  task automatic drive_vec(input vec_t v);
    if (v.gnt) begin
      bus.req_valid   = 2'b10;
      bus.req_aluctrl = {v.ctrl, 3'b111};
      bus.req_srca    = {v.a, 32'hDEADBEEF};
      bus.req_srcb    = {v.b, 32'h00000005};
    end else begin
      bus.req_valid   = 2'b01;
      bus.req_aluctrl = {3'b111, v.ctrl};
      bus.req_srca    = {32'hDEADBEEF, v.a};
      bus.req_srcb    = {32'h00000005, v.b};
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] oh;
    oh = v.gnt ? 2'b10 : 2'b01;
    drive_vec(v);
    bus.rsp_ready = 2'b11;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
    chk("issue_alu_ctrl", 32'(alu_ctrl), 32'(v.ctrl));
    chk("issue_alu_srca", alu_srca, v.a);
    chk("issue_alu_srcb", alu_srcb, v.b);
    tick();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    chk("rsp_result", bus.rsp_result, v.res);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(v.zero));
    tick();
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    $display("vec %0d: gnt=%0d ctrl=%b a=%h b=%h -> result=%h zero=%0d",
             idx, v.gnt, v.ctrl, v.a, v.b, v.res, v.zero);
  endtask

  logic [1:0]  exp_oh;
  logic [31:0] exp_res;
  vec_t        vtmp;

  initial begin
    vecs[0] = '{1'b0, 3'b001, 32'h0000000A, 32'h0000000A, 32'h00000000, 1'b1};
    vecs[1] = '{1'b1, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[2] = '{1'b0, 3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[3] = '{1'b1, 3'b011, 32'h12000000, 32'h00000034, 32'h12000034, 1'b0};
    vecs[4] = '{1'b0, 3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[5] = '{1'b1, 3'b101, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1};
    vecs[6] = '{1'b0, 3'b110, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[7] = '{1'b1, 3'b111, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vecs[8] = '{1'b0, 3'b100, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000, 1'b1};
    vecs[9] = '{1'b1, 3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};

    rst_n           = 1'b0;
    bus.req_valid   = 2'b11;
    bus.req_aluctrl = 6'b011_010;
    bus.req_srca    = {32'h11111111, 32'h22222222};
    bus.req_srcb    = {32'h33333333, 32'h44444444};
    bus.rsp_ready   = 2'b11;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_srcb", alu_srcb, 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    $display("reset: values checked while rst_n low");
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Contention: both requesters valid continuously from reset.
    do_reset();
    bus.req_valid   = 2'b11;
    bus.req_aluctrl = {3'b100, 3'b000};
    bus.req_srca    = {32'h000000F0, 32'h00000001};
    bus.req_srcb    = {32'h0000000F, 32'h00000002};
    bus.rsp_ready   = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_oh  = 2'b01;
      exp_res = 32'h3;
`else
      exp_oh  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (k % 2 == 0) ? 32'h3 : 32'hFF;
`endif
      #1;
      chk("cont_req_ready", 32'(bus.req_ready), 32'(exp_oh));
      tick();
      tick();
      chk("cont_rsp_valid", 32'(bus.rsp_valid), 32'(exp_oh));
      chk("cont_rsp_result", bus.rsp_result, exp_res);
      $display("contention %0d: rsp_valid=%b result=%h", k, bus.rsp_valid, bus.rsp_result);
      tick();
    end

    // Backpressure, wrong-requester ready, and req1 accepted right after.
    do_reset();
    bus.req_valid   = 2'b01;
    bus.req_aluctrl = {3'b011, 3'b010};
    bus.req_srca    = {32'h00000100, 32'hFF00FF00};
    bus.req_srcb    = {32'h00000023, 32'h0FF00FF0};
    bus.rsp_ready   = 2'b00;
    #1;
    chk("bp_req_ready0", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b10;
    #1;
    chk("bp_issue_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.rsp_ready = (k < 2) ? 2'b00 : 2'b10;
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_result", bus.rsp_result, 32'h0F000F00);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      $display("backpressure %0d: rsp_ready=%b rsp_valid=%b", k, bus.rsp_ready, bus.rsp_valid);
      tick();
    end
    bus.rsp_ready = 2'b01;
    #1;
    chk("bp_hs_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    chk("bp_next_req_ready", 32'(bus.req_ready), 32'd2);
    chk("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    chk("bp_req1_alu_ctrl", 32'(alu_ctrl), 32'd3);
    tick();
    chk("bp_req1_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    chk("bp_req1_result", bus.rsp_result, 32'h00000123);
    $display("backpressure: req1 result=%h", bus.rsp_result);
    tick();

    // Reset in ISSUE with ptr pointing at requester 1.
    do_reset();
    vtmp = '{1'b0, 3'b000, 32'h00000005, 32'h00000006, 32'h0000000B, 1'b0};
    run_vec(10, vtmp);
    vtmp = '{1'b1, 3'b001, 32'h00000009, 32'h00000004, 32'h00000005, 1'b0};
    drive_vec(vtmp);
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 32'd2);
    tick();
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mr_alu_srca", alu_srca, 32'd0);
    chk("mr_alu_srcb", alu_srcb, 32'd0);
    chk("mr_rsp_result", bus.rsp_result, 32'd0);
    chk("mr_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mr_post_busy", 32'(busy), 32'd0);
    end
    $display("reset mid-op: no response after release");
    bus.req_valid   = 2'b11;
    bus.req_aluctrl = {3'b100, 3'b000};
    bus.req_srca    = {32'h000000F0, 32'h00000001};
    bus.req_srcb    = {32'h0000000F, 32'h00000002};
    bus.rsp_ready   = 2'b11;
    #1;
    chk("mr_first_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("mr_first_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("mr_first_result", bus.rsp_result, 32'h3);
    $display("reset mid-op: first request after reset result=%h", bus.rsp_result);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
